// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/BTB branch predictor: counter encodings,
// controller states and the PC field extraction used for BTB index and tag.
package bp_pkg;

  localparam int unsigned BP_DBITS = 32;

  localparam logic [1:0] PHT_SNT = 2'd0;
  localparam logic [1:0] PHT_WNT = 2'd1;
  localparam logic [1:0] PHT_WT  = 2'd2;
  localparam logic [1:0] PHT_ST  = 2'd3;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Callers truncate the result to the index or tag width they need.
  function automatic logic [BP_DBITS-1:0] bp_pc_field(input logic [BP_DBITS-1:0] pc,
                                                      input int unsigned       lsb);
    return pc >> lsb;
  endfunction

endpackage

// File: rtl/bp_sat_ctr2.sv
// Next-state logic of a 2-bit saturating direction counter (SNT..ST).
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    case (cnt_i)
      PHT_SNT: cnt_o = inc_i ? PHT_WNT : PHT_SNT;
      PHT_WNT: cnt_o = inc_i ? PHT_WT  : PHT_SNT;
      PHT_WT:  cnt_o = inc_i ? PHT_ST  : PHT_WNT;
      PHT_ST:  cnt_o = inc_i ? PHT_ST  : PHT_WT;
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a tagged direct-mapped BTB, speculative GHR
// with mispredict repair, post-reset table sweep and saturating perf counters.
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int unsigned DBITS        = BP_DBITS,
  parameter int unsigned HIST_BITS    = 8,
  parameter int unsigned BTB_IDX_BITS = 4,
  parameter int unsigned TAG_BITS     = 26,
  parameter int unsigned PERF_BITS    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid_i,
  input  logic [DBITS-1:0]     pred_pc_i,
  output logic                 pred_ready_o,
  output logic                 pred_taken_o,
  output logic [DBITS-1:0]     pred_target_o,
  output logic [HIST_BITS-1:0] pred_hist_o,
  input  logic                 upd_valid_i,
  input  logic [DBITS-1:0]     upd_pc_i,
  input  logic [HIST_BITS-1:0] upd_hist_i,
  input  logic                 upd_taken_i,
  input  logic [DBITS-1:0]     upd_target_i,
  input  logic                 upd_mispred_i,
  output logic [PERF_BITS-1:0] perf_lookups_o,
  output logic [PERF_BITS-1:0] perf_mispred_o
);

  localparam int unsigned PHT_N     = 2 ** HIST_BITS;
  localparam int unsigned BTB_N     = 2 ** BTB_IDX_BITS;
  localparam int unsigned INIT_BITS = (HIST_BITS > BTB_IDX_BITS) ? HIST_BITS : BTB_IDX_BITS;
  localparam int unsigned INIT_LAST = ((PHT_N > BTB_N) ? PHT_N : BTB_N) - 1;

  bp_state_e              state_q, state_d;
  logic [INIT_BITS-1:0]   init_idx_q, init_idx_d;
  logic [31:0]            init_idx_ext_s;
  logic [HIST_BITS-1:0]   ghr_q, ghr_d;
  logic [PERF_BITS-1:0]   perf_lk_q, perf_lk_d;
  logic [PERF_BITS-1:0]   perf_mp_q, perf_mp_d;

  logic [1:0]             pht_q [PHT_N];
  logic                   btb_valid_q [BTB_N];
  logic [TAG_BITS-1:0]    btb_tag_q [BTB_N];
  logic [DBITS-1:0]       btb_target_q [BTB_N];

  logic                   run_s;
  logic [HIST_BITS-1:0]   pidx_s, uidx_s, pht_widx_s;
  logic [BTB_IDX_BITS-1:0] pbidx_s, ubidx_s, btb_widx_s;
  logic [TAG_BITS-1:0]    ptag_s, utag_s, btb_wtag_s;
  logic                   hit_s, taken_s;
  logic [1:0]             pht_cur_s, pht_next_s, pht_wdata_s;
  logic                   pht_we_s, btb_we_s, btb_wvalid_s;
  logic [DBITS-1:0]       btb_wtarget_s;

  assign run_s          = (state_q == BP_RUN);
  assign init_idx_ext_s = 32'(init_idx_q);

  // Lookup path: pure read of the current tables and GHR.
  always_comb begin
    pidx_s  = pred_pc_i[HIST_BITS+1:2] ^ ghr_q;
    pbidx_s = BTB_IDX_BITS'(bp_pc_field(BP_DBITS'(pred_pc_i), 32'd2));
    ptag_s  = TAG_BITS'(bp_pc_field(BP_DBITS'(pred_pc_i), BTB_IDX_BITS + 32'd2));
    hit_s   = run_s && btb_valid_q[pbidx_s] && (btb_tag_q[pbidx_s] == ptag_s);
    taken_s = hit_s && pht_q[pidx_s][1];
    pred_ready_o  = run_s;
    pred_taken_o  = taken_s;
    pred_target_o = taken_s ? btb_target_q[pbidx_s] : (pred_pc_i + DBITS'(4));
    pred_hist_o   = ghr_q;
  end

  assign uidx_s    = upd_pc_i[HIST_BITS+1:2] ^ upd_hist_i;
  assign ubidx_s   = BTB_IDX_BITS'(bp_pc_field(BP_DBITS'(upd_pc_i), 32'd2));
  assign utag_s    = TAG_BITS'(bp_pc_field(BP_DBITS'(upd_pc_i), BTB_IDX_BITS + 32'd2));
  assign pht_cur_s = pht_q[uidx_s];

  bp_sat_ctr2 u_upd_ctr (
    .cnt_i (pht_cur_s),
    .inc_i (upd_taken_i),
    .cnt_o (pht_next_s)
  );

  // Controller next state: sweep counter, GHR and perf counters.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    perf_lk_d  = perf_lk_q;
    perf_mp_d  = perf_mp_q;
    case (state_q)
      BP_INIT: begin
        init_idx_d = init_idx_q + INIT_BITS'(1);
        if (init_idx_q == INIT_BITS'(INIT_LAST)) begin
          state_d = BP_RUN;
        end else begin
          state_d = BP_INIT;
        end
      end
      BP_RUN: begin
        // Repair from the resolved branch wins over this cycle's speculative shift.
        if (upd_valid_i && upd_mispred_i) begin
          ghr_d = {upd_hist_i[HIST_BITS-2:0], upd_taken_i};
        end else if (pred_valid_i && hit_s) begin
          ghr_d = {ghr_q[HIST_BITS-2:0], taken_s};
        end else begin
          ghr_d = ghr_q;
        end
        if (pred_valid_i && (perf_lk_q != {PERF_BITS{1'b1}})) begin
          perf_lk_d = perf_lk_q + PERF_BITS'(1);
        end else begin
          perf_lk_d = perf_lk_q;
        end
        if (upd_valid_i && upd_mispred_i && (perf_mp_q != {PERF_BITS{1'b1}})) begin
          perf_mp_d = perf_mp_q + PERF_BITS'(1);
        end else begin
          perf_mp_d = perf_mp_q;
        end
      end
      default: state_d = BP_INIT;
    endcase
  end

  // Table write selection: sweep entries during INIT, resolved branches during RUN.
  always_comb begin
    pht_we_s      = 1'b0;
    pht_widx_s    = uidx_s;
    pht_wdata_s   = pht_next_s;
    btb_we_s      = 1'b0;
    btb_widx_s    = ubidx_s;
    btb_wvalid_s  = 1'b1;
    btb_wtag_s    = utag_s;
    btb_wtarget_s = upd_target_i;
    if (state_q == BP_INIT) begin
      pht_we_s      = (init_idx_ext_s < PHT_N);
      pht_widx_s    = init_idx_q[HIST_BITS-1:0];
      pht_wdata_s   = PHT_WNT;
      btb_we_s      = (init_idx_ext_s < BTB_N);
      btb_widx_s    = init_idx_q[BTB_IDX_BITS-1:0];
      btb_wvalid_s  = 1'b0;
      btb_wtag_s    = '0;
      btb_wtarget_s = '0;
    end else begin
      pht_we_s = upd_valid_i;
      btb_we_s = upd_valid_i && upd_taken_i;
    end
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
      perf_lk_q  <= '0;
      perf_mp_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
      perf_lk_q  <= perf_lk_d;
      perf_mp_q  <= perf_mp_d;
    end
  end

  // Table storage; contents are established by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (reset && pht_we_s) begin
      pht_q[pht_widx_s] <= pht_wdata_s;
    end
    if (reset && btb_we_s) begin
      btb_valid_q[btb_widx_s]  <= btb_wvalid_s;
      btb_tag_q[btb_widx_s]    <= btb_wtag_s;
      btb_target_q[btb_widx_s] <= btb_wtarget_s;
    end
  end

  assign perf_lookups_o = perf_lk_q;
  assign perf_mispred_o = perf_mp_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor with a table-level reference model
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_hist;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_hist;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [3:0]  perf_lookups;
  logic [3:0]  perf_mispred;

  int vectors = 0;
  int miscompares = 0;

  gshare_btb_predictor #(.PERF_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .pred_valid_i   (pred_valid),
    .pred_pc_i      (pred_pc),
    .pred_ready_o   (pred_ready),
    .pred_taken_o   (pred_taken),
    .pred_target_o  (pred_target),
    .pred_hist_o    (pred_hist),
    .upd_valid_i    (upd_valid),
    .upd_pc_i       (upd_pc),
    .upd_hist_i     (upd_hist),
    .upd_taken_i    (upd_taken),
    .upd_target_i   (upd_target),
    .upd_mispred_i  (upd_mispred),
    .perf_lookups_o (perf_lookups),
    .perf_mispred_o (perf_mispred)
  );

  always #5 clk = ~clk;

  // Reference model: whole-table view; the post-reset sweep is a 256-cycle blackout
  // after which every table entry is simply in its cleared state.
  int          m_pht [256];
  bit          m_bv  [16];
  logic [25:0] m_bt  [16];
  logic [31:0] m_btgt[16];
  int          m_ghr = 0;
  int          m_init_left = 256;
  int          m_lk = 0;
  int          m_mp = 0;
  bit          armed = 1'b0;

  function automatic bit m_hit(input logic [31:0] pc);
    int b;
    b = int'((pc >> 2) & 32'd15);
    return m_bv[b] && (m_bt[b] == pc[31:6]);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int p;
    p = int'((pc >> 2) & 32'd255) ^ m_ghr;
    return m_hit(pc) && (m_pht[p] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    if (m_taken(pc)) return m_btgt[int'((pc >> 2) & 32'd15)];
    return pc + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int new_ghr, u, b;
    bit t;
    if (!reset) begin
      m_init_left = 256;
      m_ghr = 0;
      m_lk = 0;
      m_mp = 0;
      armed = 1'b1;
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) begin
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
      end
    end else begin
      new_ghr = m_ghr;
      if (pred_valid) begin
        if (m_lk < 15) m_lk++;
        if (m_hit(pred_pc)) begin
          t = m_taken(pred_pc);
          new_ghr = ((m_ghr << 1) | int'(t)) & 255;
        end
      end
      if (upd_valid) begin
        u = int'((upd_pc >> 2) & 32'd255) ^ int'(upd_hist);
        if (upd_taken) m_pht[u] = (m_pht[u] == 3) ? 3 : m_pht[u] + 1;
        else           m_pht[u] = (m_pht[u] == 0) ? 0 : m_pht[u] - 1;
        if (upd_taken) begin
          b = int'((upd_pc >> 2) & 32'd15);
          m_bv[b]   = 1'b1;
          m_bt[b]   = upd_pc[31:6];
          m_btgt[b] = upd_target;
        end
        if (upd_mispred) begin
          new_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & 255;
          if (m_mp < 15) m_mp++;
        end
      end
      m_ghr = new_ghr;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("ready", 32'(pred_ready), 32'(m_init_left == 0));
      chk("taken", 32'(pred_taken), (m_init_left == 0) ? 32'(m_taken(pred_pc)) : 32'd0);
      chk("target", pred_target, (m_init_left == 0) ? m_target(pred_pc) : pred_pc + 32'd4);
      chk("hist", 32'(pred_hist), 32'(m_ghr));
      chk("perf_lookups", 32'(perf_lookups), 32'(m_lk));
      chk("perf_mispred", 32'(perf_mispred), 32'(m_mp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] hist, input logic tk,
                     input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_hist = hist; upd_taken = tk;
    upd_target = tgt; upd_mispred = mis;
    tick();
    upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (pred_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'd256);
  endtask

  initial begin
    reset = 1'b0; pred_valid = 1'b0; pred_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_hist = 8'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_mispred = 1'b0;

    // Reset and sweep length
    tick();
    reset = 1'b1;
    #1;
    chk("init_ready_low", 32'(pred_ready), 32'd0);
    wait_ready("init_cycles");
    pred_pc = 32'h0000_0100; #1;
    chk("cold_taken", 32'(pred_taken), 32'd0);
    chk("cold_target", pred_target, 32'h0000_0104);

    // Train taken, then lookup with GHR=0
    upd(32'h100, 8'h00, 1'b1, 32'h400, 1'b0);
    upd(32'h100, 8'h00, 1'b1, 32'h400, 1'b0);
    pred_pc = 32'h100; pred_valid = 1'b1; #1;
    chk("t2_taken", 32'(pred_taken), 32'd1);
    chk("t2_target", pred_target, 32'h400);
    chk("t2_hist", 32'(pred_hist), 32'h00);
    tick();
    pred_valid = 1'b0; #1;
    chk("t2_hist_shift", 32'(pred_hist), 32'h01);

    // Down to SNT, hold there, repair GHR to 0 with the last update
    upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 8'h00, 1'b0, 32'h0, 1'b1);
    pred_pc = 32'h100; pred_valid = 1'b1; #1;
    chk("t3_taken", 32'(pred_taken), 32'd0);
    chk("t3_target", pred_target, 32'h104);
    tick();
    pred_valid = 1'b0;
    upd(32'h100, 8'h00, 1'b1, 32'h400, 1'b0);
    #1;
    chk("t3_weak_nt", 32'(pred_taken), 32'd0);
    upd(32'h100, 8'h00, 1'b1, 32'h400, 1'b0);
    pred_valid = 1'b1; #1;
    chk("t3_retrained", 32'(pred_taken), 32'd1);
    tick();
    pred_valid = 1'b0;

    // Aliasing BTB index, different tag
    pred_pc = 32'h140; pred_valid = 1'b1; #1;
    chk("t4_taken", 32'(pred_taken), 32'd0);
    chk("t4_target", pred_target, 32'h144);
    tick();
    pred_valid = 1'b0; #1;
    chk("t4_no_shift", 32'(pred_hist), 32'h01);

    // Hit lookup + same-cycle mispredict repair
    pred_pc = 32'h100; pred_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h200; upd_hist = 8'hA5; upd_taken = 1'b0;
    upd_target = 32'h0; upd_mispred = 1'b1; #1;
    chk("t5_taken", 32'(pred_taken), 32'd0);
    tick();
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0; #1;
    chk("t5_repair", 32'(pred_hist), 32'h4A);

    // Read-before-write: counter at 0x0A goes 1->2 this cycle
    pred_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_hist = 8'h4A; upd_taken = 1'b1;
    upd_target = 32'h400; #1;
    chk("rbw_before", 32'(pred_taken), 32'd0);
    tick();
    upd_valid = 1'b0; #1;
    chk("rbw_after", 32'(pred_taken), 32'd1);

    // Mixed directed traffic checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pcs [6];
      pcs = '{32'h100, 32'h140, 32'h200, 32'hFFFF_FFFC, 32'h3FC, 32'h104};
      pred_pc     = pcs[i % 6];
      pred_valid  = (i % 3) != 0;
      upd_valid   = (i % 2) == 0;
      upd_pc      = pcs[(i + 3) % 6];
      upd_hist    = 8'((i * 37) & 255);
      upd_taken   = (i % 5) < 3;
      upd_target  = 32'h1000 + 32'(i * 16);
      upd_mispred = (i % 4) == 0;
      tick();
    end
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0; #1;
    chk("perf_lk_sat", 32'(perf_lookups), 32'd15);

    // Reset mid-run
    reset = 1'b0;
    tick();
    reset = 1'b1; #1;
    chk("rst_ready", 32'(pred_ready), 32'd0);
    chk("rst_perf_lk", 32'(perf_lookups), 32'd0);
    chk("rst_perf_mp", 32'(perf_mispred), 32'd0);
    chk("rst_hist", 32'(pred_hist), 32'd0);
    wait_ready("reinit_cycles");
    pred_pc = 32'h100; #1;
    chk("reinit_taken", 32'(pred_taken), 32'd0);
    chk("reinit_target", pred_target, 32'h104);
    pred_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_target", pred_target, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
